// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the write-back trace buffer.
package wb_trace_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_write_t;

    // One extra MSB over the address lets full and empty be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Generic show-ahead synchronous FIFO, DEPTH (power of 2, >= 2) x WIDTH, with
// synchronous flush. Read data is forced to zero while empty.
module sync_fifo import wb_trace_pkg::*; #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o
);

    localparam int ADDR_W = PTR_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_pop_s  = pop_i && !empty_s;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push_s = push_i && (!full_s || do_pop_s);

    // Pointer next-state: flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; left unreset so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !clr_i) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Time-stamped trace of regfile write-back events drained over valid/ready.
// Optional register filter: define WB_TRACE_FILTER_EN to add the reg_mask port.
module wb_trace_buffer import wb_trace_pkg::*; #(
    parameter  int DEPTH  = 16,
    parameter  int CYC_W  = 16,
    parameter  int DROP_W = 8,
    localparam int CNT_W  = ptr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              ctrl_writeEnable,
    input  logic [REG_W-1:0]  ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
`ifdef WB_TRACE_FILTER_EN
    input  logic [31:0]       reg_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CYC_W-1:0]  out_cycle,
    output logic [REG_W-1:0]  out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    typedef struct packed {
        logic [CYC_W-1:0] cycle;
        wb_write_t        wb;
    } entry_t;

    logic [CYC_W-1:0]  cyc_q;
    logic [CYC_W-1:0]  cyc_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;
    logic              reg_sel_s;
    logic              capture_s;
    logic              pop_fire_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    entry_t            wr_entry_s;
    entry_t            head_s;

`ifdef WB_TRACE_FILTER_EN
    assign reg_sel_s = reg_mask[ctrl_writeReg];
`else
    assign reg_sel_s = 1'b1;
`endif

    // r0 is excluded here, which also makes reg_mask[0] irrelevant.
    assign capture_s  = ctrl_writeEnable && (ctrl_writeReg != {REG_W{1'b0}}) && reg_sel_s;
    assign pop_fire_s = !empty_s && out_ready && !clear;
    assign drop_s     = capture_s && full_s && !pop_fire_s && !clear;

    assign wr_entry_s.cycle   = cyc_q;
    assign wr_entry_s.wb.rd   = ctrl_writeReg;
    assign wr_entry_s.wb.data = data_writeReg;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (clear),
        .push_i  (capture_s && !clear),
        .wdata_i (wr_entry_s),
        .pop_i   (out_ready && !clear),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count)
    );

    // Cycle stamp, sticky overflow and saturating drop counter next-state.
    always_comb begin
        cyc_d  = cyc_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear) begin
            cyc_d  = {CYC_W{1'b0}};
            ovf_d  = 1'b0;
            drop_d = {DROP_W{1'b0}};
        end else begin
            cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
            if (drop_s) begin
                ovf_d = 1'b1;
                if (drop_q != {DROP_W{1'b1}}) begin
                    drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
                end else begin
                    drop_d = drop_q;
                end
            end else begin
                ovf_d  = ovf_q;
                drop_d = drop_q;
            end
        end
    end

    // Counter and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q  <= {CYC_W{1'b0}};
            ovf_q  <= 1'b0;
            drop_q <= {DROP_W{1'b0}};
        end else begin
            cyc_q  <= cyc_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign out_valid  = !empty_s;
    assign out_cycle  = head_s.cycle;
    assign out_reg    = head_s.wb.rd;
    assign out_data   = head_s.wb.data;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule
